// File: rtl/jtcop_dispgate.sv
`default_nettype none
// ============================================================================
//  Module   : jtcop_dispgate
//  Purpose  : Display-bus access gate for the 68000 main CPU glue. CPU
//             accesses to display chips are held in a wait state until a
//             video blank, then for DLY cpu_cen ticks, before being granted.
//             Each of CH chip-select channels is either blank-gated or free.
//             An optional watchdog (TOUT) forces a grant, and a saturating
//             stall counter records how many clk cycles busy was high.
//  Ports    : clk, rstn (async, active low), cpu_cen, LHBL/LVBL (active-low
//             blanks), ch_cs/ch_free (per-channel select/mode), stat_clr
//             -> busy (wait request), grant (one-hot channel), tout_flag
//             (sticky forced grant), stall_cnt (saturating busy cycles)
//  Revision : 1.0  initial release
// ============================================================================
module jtcop_dispgate #(
  parameter int CH   = 4,
  parameter int DLYW = 2,
  parameter int DLY  = 3,
  parameter int TOW  = 16,
  parameter int TOUT = 0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cpu_cen,
  input  logic          LHBL,
  input  logic          LVBL,
  input  logic [CH-1:0] ch_cs,
  input  logic [CH-1:0] ch_free,
  input  logic          stat_clr,
  output logic          busy,
  output logic [CH-1:0] grant,
  output logic          tout_flag,
  output logic [15:0]   stall_cnt
);

  localparam logic [DLYW-1:0] DLY_LOAD = DLYW'(DLY);
  localparam logic [TOW-1:0]  TO_LAST  = TOW'((TOUT > 0) ? (TOUT - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DELAY = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t          state, state_nx;
  logic            cs_l;
  logic [CH-1:0]   sel_oh, sel_nx;
  logic [DLYW-1:0] cnt, cnt_nx;
  logic [TOW-1:0]  tocnt, tocnt_nx;
  logic            busy_nx;
  logic [CH-1:0]   grant_nx;
  logic            tout_set;

  logic            cs_any, blank, start;
  logic [CH-1:0]   low_bit;

  assign cs_any  = |ch_cs;
  assign blank   = ~LHBL | ~LVBL;
  assign start   = cs_any & ~cs_l;
  // Two's-complement trick isolates the lowest set chip select, so when
  // several selects are active the lowest index wins without a priority loop.
  assign low_bit = ch_cs & (~ch_cs + CH'(1));

  always_comb begin
    state_nx = state;
    busy_nx  = busy;
    grant_nx = grant;
    sel_nx   = sel_oh;
    cnt_nx   = cnt;
    tocnt_nx = tocnt;
    tout_set = 1'b0;
    if (!cs_any) begin
      // Losing the chip select aborts whatever is in flight.
      state_nx = ST_IDLE;
      busy_nx  = 1'b0;
      grant_nx = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            sel_nx = low_bit;
            if (|(low_bit & ch_free)) begin
              grant_nx = low_bit;
              state_nx = ST_DONE;
            end else begin
              busy_nx  = 1'b1;
              grant_nx = '0;
              tocnt_nx = '0;
              state_nx = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // Blank is tested first so a coincident timeout never flags.
          if (blank) begin
            cnt_nx   = DLY_LOAD;
            state_nx = ST_DELAY;
          end else if (TOUT != 0) begin
            if (tocnt == TO_LAST) begin
              tout_set = 1'b1;
              cnt_nx   = DLY_LOAD;
              state_nx = ST_DELAY;
            end else begin
              tocnt_nx = tocnt + TOW'(1);
            end
          end
        end
        ST_DELAY: begin
          // Committed: blank may drop here without affecting completion.
          if (cnt == '0) begin
            busy_nx  = 1'b0;
            grant_nx = sel_oh;
            state_nx = ST_DONE;
          end else if (cpu_cen) begin
            cnt_nx = cnt - DLYW'(1);
          end
        end
        default: begin
          // ST_DONE holds the grant; the abort path above releases it.
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= ST_IDLE;
      cs_l   <= 1'b0;
      sel_oh <= '0;
      cnt    <= '0;
      tocnt  <= '0;
      busy   <= 1'b0;
      grant  <= '0;
    end else begin
      state  <= state_nx;
      cs_l   <= cs_any;
      sel_oh <= sel_nx;
      cnt    <= cnt_nx;
      tocnt  <= tocnt_nx;
      busy   <= busy_nx;
      grant  <= grant_nx;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tout_flag <= 1'b0;
      stall_cnt <= '0;
    end else if (stat_clr) begin
      tout_flag <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (tout_set) tout_flag <= 1'b1;
      if (busy && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jtcop_dispgate.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jtcop_dispgate
//  Purpose  : Self-checking bench for jtcop_dispgate. Two instances share the
//             stimulus: one without watchdog, one with TOUT=50. Each access is
//             predicted at transaction level (busy length, grant time/value,
//             stall total, timeout flag) from the gating rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_jtcop_dispgate;

  localparam int DLY  = 3;
  localparam int TO1  = 50;
  localparam int LIM  = 400;

  logic       clk = 1'b0;
  logic       rstn;
  logic       cpu_cen;
  logic       LHBL, LVBL;
  logic [3:0] ch_cs, ch_free;
  logic       stat_clr;

  logic       busy0, busy1, tout0, tout1;
  logic [3:0] grant0, grant1;
  logic [15:0] stall0, stall1;

  int n_cmp = 0;
  int n_err = 0;
  int exp_stall[2];
  int exp_tout[2];
  bit blank_h;

  always #5 clk = ~clk;

  jtcop_dispgate #(.CH(4), .DLYW(2), .DLY(DLY), .TOW(16), .TOUT(0)) dut0 (
    .clk(clk), .rstn(rstn), .cpu_cen(cpu_cen), .LHBL(LHBL), .LVBL(LVBL),
    .ch_cs(ch_cs), .ch_free(ch_free), .stat_clr(stat_clr),
    .busy(busy0), .grant(grant0), .tout_flag(tout0), .stall_cnt(stall0));

  jtcop_dispgate #(.CH(4), .DLYW(2), .DLY(DLY), .TOW(16), .TOUT(TO1)) dut1 (
    .clk(clk), .rstn(rstn), .cpu_cen(cpu_cen), .LHBL(LHBL), .LVBL(LVBL),
    .ch_cs(ch_cs), .ch_free(ch_free), .stat_clr(stat_clr),
    .busy(busy1), .grant(grant1), .tout_flag(tout1), .stall_cnt(stall1));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_blank(input bit b);
    if (blank_h) begin LHBL = ~b; LVBL = 1'b1; end
    else         begin LVBL = ~b; LHBL = 1'b1; end
  endtask

  function automatic bit cen_at(input int j, input int p, input int ph);
    return ((j + ph) % p) == 0;
  endfunction

  // Edge index at which the delay counter is observed at zero.
  function automatic int calc_d(input int w, input int p, input int ph);
    int n = 0;
    if (DLY == 0) return w;
    for (int j = w + 1; j < w + 100; j++) begin
      if (cen_at(j, p, ph)) n++;
      if (n == DLY) return j;
    end
    return -1;
  endfunction

  function automatic logic [3:0] lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++)
      if (v[i]) return 4'(1 << i);
    return 4'd0;
  endfunction

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic check_stats();
    check_val("stall0", 32'(stall0), 32'(exp_stall[0]));
    check_val("stall1", 32'(stall1), 32'(exp_stall[1]));
    check_val("tout0",  32'(tout0),  32'(exp_tout[0]));
    check_val("tout1",  32'(tout1),  32'(exp_tout[1]));
  endtask

  // One access: tb = first edge index with blank, p/ph = cen period/phase,
  // ab = edge at which the chip select is dropped (0 = no abort).
  task automatic run_txn(input logic [3:0] cs, input logic [3:0] fr, input int tb,
                         input int p, input int ph, input int ab);
    logic [3:0] low;
    bit gated;
    int b1, d0, d1, w1, len0, len1, gi0, gi1;
    int bc0 = 0, bc1 = 0, g0 = -1, g1 = -1;
    logic [3:0] gv0 = '0, gv1 = '0;
    bit to1;

    low   = lowest(cs);
    gated = ((low & fr) == 4'd0);
    b1    = (tb < 1) ? 1 : tb;
    d0    = calc_d(b1, p, ph);
    w1    = (b1 > TO1) ? TO1 : b1;
    to1   = gated && (b1 > TO1);
    d1    = calc_d(w1, p, ph);
    len0  = gated ? d0 + 1 : 0;
    len1  = gated ? d1 + 1 : 0;
    gi0   = gated ? d0 + 1 : 0;
    gi1   = gated ? d1 + 1 : 0;

    ch_cs = cs; ch_free = fr;
    drive_blank(0 >= tb);
    cpu_cen = cen_at(0, p, ph);
    for (int j = 0; j < LIM; j++) begin
      step();
      if (busy0) bc0++;
      if (busy1) bc1++;
      if (g0 < 0 && grant0 != 0) begin g0 = j; gv0 = grant0; end
      if (g1 < 0 && grant1 != 0) begin g1 = j; gv1 = grant1; end
      if (ab > 0 && j == ab) break;
      if (ab > 0 && j == ab - 1) ch_cs = 4'd0;
      if (ab == 0 && g0 >= 0 && g1 >= 0) break;
      drive_blank(j + 1 >= tb);
      cpu_cen = cen_at(j + 1, p, ph);
    end

    if (ab > 0) begin
      check_val("abort_len0", 32'(bc0), 32'(ab));
      check_val("abort_len1", 32'(bc1), 32'(ab));
      check_val("abort_busy", {30'd0, busy0, busy1}, 32'd0);
      check_val("abort_gnt",  {24'd0, grant0, grant1}, 32'd0);
      exp_stall[0] = sat(exp_stall[0] + ab);
      exp_stall[1] = sat(exp_stall[1] + ab);
    end else begin
      check_val("busy_len0", 32'(bc0), 32'(len0));
      check_val("busy_len1", 32'(bc1), 32'(len1));
      check_val("gnt_at0",   32'(g0),  32'(gi0));
      check_val("gnt_at1",   32'(g1),  32'(gi1));
      check_val("gnt0",      32'(gv0), 32'(low));
      check_val("gnt1",      32'(gv1), 32'(low));
      exp_stall[0] = sat(exp_stall[0] + len0);
      exp_stall[1] = sat(exp_stall[1] + len1);
      if (to1) exp_tout[1] = 1;
    end
    check_stats();

    ch_cs = 4'd0;
    drive_blank(1'b0);
    step();
    check_val("rel_gnt",  {24'd0, grant0, grant1}, 32'd0);
    check_val("rel_busy", {30'd0, busy0, busy1}, 32'd0);
    step();
  endtask

  task automatic do_stat_clr();
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    exp_stall = '{0, 0};
    exp_tout  = '{0, 0};
    check_stats();
  endtask

  initial begin
    logic [3:0] cs, fr;
    int tb, ab;

    rstn = 1'b0; cpu_cen = 1'b0; LHBL = 1'b1; LVBL = 1'b1;
    ch_cs = '0; ch_free = '0; stat_clr = 1'b0; blank_h = 1'b1;
    exp_stall = '{0, 0};
    exp_tout  = '{0, 0};
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", {30'd0, busy0, busy1}, 32'd0);
    check_val("rst_gnt",  {24'd0, grant0, grant1}, 32'd0);
    check_stats();
    @(negedge clk);
    rstn = 1'b1;
    step();

    // Gated during active video, blank at edge 100, cen every 4th clk.
    run_txn(4'b0001, 4'b0000, 100, 4, 0, 0);
    // Free channel.
    run_txn(4'b0100, 4'b0100, 0, 1, 0, 0);
    // Access starting inside vertical blank, cen every clk: 5 busy clk.
    blank_h = 1'b0;
    run_txn(4'b0010, 4'b0000, 0, 1, 0, 0);
    blank_h = 1'b1;
    // Abort during WAIT, followed by a clean restart.
    run_txn(4'b1000, 4'b0000, 90, 2, 1, 17);
    run_txn(4'b1000, 4'b0000, 3, 2, 1, 0);
    // Timeout forced on the watchdog instance, then statistics clear.
    run_txn(4'b0001, 4'b0000, 80, 1, 0, 0);
    do_stat_clr();

    // Random accesses.
    for (int k = 0; k < 24; k++) begin
      cs = 4'($urandom_range(1, 15));
      fr = 4'($urandom_range(0, 15));
      blank_h = 1'($urandom_range(0, 1));
      ab = 0;
      tb = $urandom_range(0, 120);
      if ($urandom_range(0, 4) == 0) begin
        fr = fr & ~lowest(cs);
        tb = $urandom_range(60, 120);
        ab = $urandom_range(1, 40);
      end
      run_txn(cs, fr, tb, $urandom_range(1, 4), $urandom_range(0, 3), ab);
    end

    // Reset asserted in DELAY: outputs clear without a clk edge.
    run_txn(4'b0001, 4'b0000, 120, 1, 0, 0);
    ch_cs = 4'b0001; ch_free = 4'b0000; drive_blank(1'b1); cpu_cen = 1'b0;
    step();
    step();
    check_val("pre_rst_busy", 32'(busy0), 32'd1);
    rstn = 1'b0;
    #1;
    check_val("arst_busy", {30'd0, busy0, busy1}, 32'd0);
    check_val("arst_gnt",  {24'd0, grant0, grant1}, 32'd0);
    exp_stall = '{0, 0};
    exp_tout  = '{0, 0};
    check_stats();
    ch_cs = 4'd0; drive_blank(1'b0);
    @(negedge clk);
    rstn = 1'b1;
    step();

    // Saturation: long stall with no blank on the non-watchdog instance.
    ch_cs = 4'b0001; ch_free = 4'b0000; LHBL = 1'b1; LVBL = 1'b1; cpu_cen = 1'b1;
    repeat (70010) step();
    exp_stall[0] = 65535;
    exp_stall[1] = sat(exp_stall[1] + TO1 + DLY + 1);
    exp_tout[1]  = 1;
    check_val("sat_busy", 32'(busy0), 32'd1);
    check_stats();
    repeat (3) step();
    check_val("sat_hold", 32'(stall0), 32'hFFFF);
    ch_cs = 4'd0;
    repeat (2) step();
    // Lowest selected channel is free: no stall, grant on channel 1.
    run_txn(4'b1010, 4'b0010, 0, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
